spi_xfer_sequencer: RTL and testbench



---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_baud_gen.sv | 39 +++
 rtl/spi_xfer_sequencer.sv | 130 +++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transfer sequencer
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_t;

  localparam int NUM_EDGES = 16;
  localparam int BAUD_W    = 3;
  // Holds the largest half-period, (7+1) << 7 = 1024.
  localparam int CNT_W     = 11;

endpackage

// File: rtl/spi_baud_gen.sv
// rtl/spi_baud_gen.sv - sclk generator: half-period counter, toggles sclk every H cycles while run
module spi_baud_gen
  import spi_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              run,
  input  logic              cpol,
  input  logic [BAUD_W-1:0] sppr,
  input  logic [BAUD_W-1:0] spr,
  output logic              sclk,
  output logic              edge_tick
);

  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] half_m1;
  logic             phase;

  assign half_m1   = ((CNT_W'(sppr) + CNT_W'(1)) << spr) - CNT_W'(1);
  assign edge_tick = run && (half_cnt == half_m1);
  // phase is cleared whenever run drops, so sclk snaps straight back to cpol
  assign sclk      = cpol ^ phase;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (edge_tick) begin
      half_cnt <= '0;
      phase    <= ~phase;
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - master-mode 8-bit transfer sequencer for the APB SPI core
// Optional SPI_OVERRUN_EN: start while busy sets sticky ovr, cleared with spif by spif_clr.
module spi_xfer_sequencer
  import spi_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              start,
  input  logic              spe,
  input  logic              mstr,
  input  logic              cpol,
  input  logic [BAUD_W-1:0] sppr,
  input  logic [BAUD_W-1:0] spr,
  input  logic              spif_clr,
  output logic              sclk,
  output logic              ss,
  output logic              send_data,
  output logic              receive_data,
  output logic              tip,
  output logic              spif,
  output logic              ovr
);

  localparam int EDGE_W = $clog2(NUM_EDGES + 1);

  spi_state_t        state;
  spi_state_t        state_nxt;
  logic              enabled;
  logic              accept;
  logic              shift_run;
  logic              edge_tick;
  logic              last_edge;
  logic              cpol_l;
  logic              cpol_eff;
  logic [BAUD_W-1:0] sppr_l;
  logic [BAUD_W-1:0] spr_l;
  logic [EDGE_W-1:0] edge_cnt;

  assign enabled   = spe && mstr;
  assign accept    = (state == ST_IDLE) && start && enabled;
  assign shift_run = (state == ST_SHIFT) && enabled;
  assign last_edge = edge_tick && (edge_cnt == EDGE_W'(NUM_EDGES - 1));
  assign cpol_eff  = (state == ST_IDLE) ? cpol : cpol_l;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_edge) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && !enabled) state_nxt = ST_IDLE;
  end

  always_comb begin
    ss           = 1'b1;
    send_data    = 1'b0;
    receive_data = 1'b0;
    tip          = 1'b0;
    case (state)
      ST_LOAD: begin
        send_data = 1'b1;
        tip       = 1'b1;
      end
      ST_SHIFT: begin
        ss  = 1'b0;
        tip = 1'b1;
      end
      ST_DONE: begin
        ss           = 1'b0;
        tip          = 1'b1;
        receive_data = enabled;
      end
      default: ;
    endcase
  end

  // Baud fields and idle level are frozen for the whole transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cpol_l <= 1'b0;
      sppr_l <= '0;
      spr_l  <= '0;
    end else if (accept) begin
      cpol_l <= cpol;
      sppr_l <= sppr;
      spr_l  <= spr;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || !shift_run) edge_cnt <= '0;
    else if (edge_tick)       edge_cnt <= edge_cnt + EDGE_W'(1);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)                                spif <= 1'b0;
    else if ((state == ST_DONE) && enabled)    spif <= 1'b1;
    else if (spif_clr)                         spif <= 1'b0;
  end

`ifdef SPI_OVERRUN_EN
  always_ff @(posedge PCLK) begin
    if (PRESET)                              ovr <= 1'b0;
    else if (start && (state != ST_IDLE))    ovr <= 1'b1;
    else if (spif_clr)                       ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
`endif

  spi_baud_gen u_baud_gen (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .run       (shift_run),
    .cpol      (cpol_eff),
    .sppr      (sppr_l),
    .spr       (spr_l),
    .sclk      (sclk),
    .edge_tick (edge_tick)
  );

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed self-checking bench for spi_xfer_sequencer
module tb_spi_xfer_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESET, start, spe, mstr, cpol, spif_clr;
  logic [2:0] sppr, spr;
  logic       sclk, ss, send_data, receive_data, tip, spif, ovr;

`ifdef SPI_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int send_cnt = 0, recv_cnt = 0, tog_cnt = 0;
  int base_send, base_recv, base_tog;
  logic prev_sclk = 1'b0;

  spi_xfer_sequencer dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .start        (start),
    .spe          (spe),
    .mstr         (mstr),
    .cpol         (cpol),
    .sppr         (sppr),
    .spr          (spr),
    .spif_clr     (spif_clr),
    .sclk         (sclk),
    .ss           (ss),
    .send_data    (send_data),
    .receive_data (receive_data),
    .tip          (tip),
    .spif         (spif),
    .ovr          (ovr)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (send_data === 1'b1) send_cnt++;
    if (receive_data === 1'b1) recv_cnt++;
    if ((sclk ^ prev_sclk) === 1'b1) tog_cnt++;
    prev_sclk = sclk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic snap();
    base_send = send_cnt;
    base_recv = recv_cnt;
    base_tog  = tog_cnt;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    PRESET = 1'b1; start = 1'b0; spe = 1'b1; mstr = 1'b1;
    cpol = 1'b0; spif_clr = 1'b0; sppr = 3'd0; spr = 3'd0;
    tick(2);
    chk("rst_sclk", sclk, 0);
    chk("rst_ss", ss, 1);
    chk("rst_send", send_data, 0);
    chk("rst_recv", receive_data, 0);
    chk("rst_tip", tip, 0);
    chk("rst_spif", spif, 0);
    chk("rst_ovr", ovr, 0);
    PRESET = 1'b0;
    tick(1);

    // H=1, cpol=0
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    chk("t1_send_c1", send_data, 1);
    chk("t1_ss_c1", ss, 1);
    chk("t1_tip_c1", tip, 1);
    tick(1);
    chk("t1_ss_c2", ss, 0);
    chk("t1_sclk_c2", sclk, 0);
    tick(1);
    chk("t1_sclk_c3", sclk, 1);
    tick(15);
    chk("t1_recv_c18", receive_data, 1);
    chk("t1_sclk_c18", sclk, 0);
    tick(1);
    chk("t1_spif_c19", spif, 1);
    chk("t1_ss_c19", ss, 1);
    chk("t1_tip_c19", tip, 0);
    chk("t1_nsend", send_cnt - base_send, 1);
    chk("t1_nrecv", recv_cnt - base_recv, 1);
    chk("t1_ntog", tog_cnt - base_tog, 16);

    // H=(2+1)<<1=6, cpol=1; config changed mid-transfer must be ignored
    spif_clr = 1'b1; cpol = 1'b1; sppr = 3'd2; spr = 3'd1;
    tick(1); spif_clr = 1'b0;
    chk("t2_spif_clr", spif, 0);
    chk("t2_idle_sclk", sclk, 1);
    tick(1);
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(1);
    chk("t2_ss_c2", ss, 0);
    chk("t2_sclk_c2", sclk, 1);
    cpol = 1'b0; sppr = 3'd0; spr = 3'd0;
    tick(5);
    chk("t2_sclk_c7", sclk, 1);
    tick(1);
    chk("t2_sclk_c8", sclk, 0);
    tick(89);
    chk("t2_tip_c97", tip, 1);
    chk("t2_recv_c97", receive_data, 0);
    chk("t2_ss_c97", ss, 0);
    tick(1);
    chk("t2_recv_c98", receive_data, 1);
    chk("t2_sclk_c98", sclk, 1);
    cpol = 1'b1;
    tick(1);
    chk("t2_ss_c99", ss, 1);
    chk("t2_spif_c99", spif, 1);
    chk("t2_ntog", tog_cnt - base_tog, 16);

    // abort after 5 edges
    spif_clr = 1'b1; cpol = 1'b0;
    tick(1); spif_clr = 1'b0;
    tick(1);
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    chk("t3_sclk_c7", sclk, 1);
    spe = 1'b0;
    tick(1);
    chk("t3_ss_abort", ss, 1);
    chk("t3_sclk_abort", sclk, 0);
    chk("t3_tip_abort", tip, 0);
    chk("t3_recv_abort", receive_data, 0);
    tick(2);
    spe = 1'b1;
    chk("t3_nrecv", recv_cnt - base_recv, 0);
    chk("t3_spif", spif, 0);
    chk("t3_nsend", send_cnt - base_send, 1);

    // start with spe=0 is ignored
    snap();
    spe = 1'b0; start = 1'b1; tick(1); start = 1'b0; spe = 1'b1;
    chk("t3b_tip", tip, 0);
    chk("t3b_send", send_data, 0);
    tick(1);
    chk("t3b_tip2", tip, 0);
    chk("t3b_nsend", send_cnt - base_send, 0);

    // repeated starts in LOAD, SHIFT and DONE
    snap();
    start = 1'b1; tick(1);
    chk("t4_send_c1", send_data, 1);
    tick(1); start = 1'b0;
    tick(3); start = 1'b1;
    tick(1); start = 1'b0;
    chk("t4_tip_c6", tip, 1);
    tick(12); start = 1'b1;
    chk("t4_recv_c18", receive_data, 1);
    tick(1); start = 1'b0;
    chk("t4_spif_c19", spif, 1);
    chk("t4_tip_c19", tip, 0);
    chk("t4_ovr_c19", ovr, OVR_EXP);
    tick(1);
    chk("t4_nsend", send_cnt - base_send, 1);
    chk("t4_nrecv", recv_cnt - base_recv, 1);
    chk("t4_tip_c20", tip, 0);
    chk("t4_ovr_c20", ovr, OVR_EXP);
    spif_clr = 1'b1; tick(1); spif_clr = 1'b0;
    chk("t4_spif_clr", spif, 0);
    chk("t4_ovr_clr", ovr, 0);

    // spif_clr against DONE, then back-to-back start
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(17);
    chk("t5_recv_c18", receive_data, 1);
    spif_clr = 1'b1;
    tick(1);
    chk("t5_spif_set_wins", spif, 1);
    start = 1'b1;
    tick(1); spif_clr = 1'b0; start = 1'b0;
    chk("t5_spif_cleared", spif, 0);
    chk("t5_b2b_send", send_data, 1);
    tick(18);
    chk("t5_tip_c38", tip, 0);
    chk("t5_spif_c38", spif, 1);
    chk("t5_ovr_c38", ovr, 0);
    chk("t5_nrecv", recv_cnt - base_recv, 2);

    // reset mid-SHIFT with H=1024
    sppr = 3'd7; spr = 3'd7;
    tick(1);
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    tick(1029);
    chk("t6_sclk_c1030", sclk, 1);
    chk("t6_ss_c1030", ss, 0);
    chk("t6_tip_c1030", tip, 1);
    PRESET = 1'b1;
    tick(1); PRESET = 1'b0;
    chk("t6_rst_sclk", sclk, 0);
    chk("t6_rst_ss", ss, 1);
    chk("t6_rst_tip", tip, 0);
    chk("t6_rst_send", send_data, 0);
    chk("t6_rst_recv", receive_data, 0);
    chk("t6_rst_spif", spif, 0);
    chk("t6_rst_ovr", ovr, 0);
    tick(3);
    chk("t6_tip_after", tip, 0);
    chk("t6_nrecv", recv_cnt - base_recv, 0);

    sppr = 3'd0; spr = 3'd0;
    tick(1);
    snap();
    start = 1'b1; tick(1); start = 1'b0;
    chk("t6f_send_c1", send_data, 1);
    tick(17);
    chk("t6f_recv_c18", receive_data, 1);
    tick(1);
    chk("t6f_spif_c19", spif, 1);
    chk("t6f_tip_c19", tip, 0);
    chk("t6f_ntog", tog_cnt - base_tog, 16);
    chk("t6f_nrecv", recv_cnt - base_recv, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
